ctrl_sequencer: RTL and testbench

- Multi-cycle control sequencer for the McCoy core; successor to the combinational opcode decoder.
- Accepts one instruction per valid/ready handshake and registers the decoded control fields.
- Holds the control fields for the instruction's lifetime and emits single-cycle write/PC strobes on completion.
- Adds parametrised opcode width, configurable memory latency for lr/sr, branch resolution and illegal-opcode trapping.

---
 rtl/ctrl_sequencer_if.sv | 20 ++
 rtl/ctrl_sequencer.sv | 147 ++++++++++++++
 tb/tb_ctrl_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ctrl_sequencer_if.sv
// Instruction handshake between the fetch side and the control sequencer.
interface ctrl_sequencer_if #(
    parameter int OPC_W = 3
);
    logic             instr_valid;
    logic             instr_ready;
    logic [OPC_W-1:0] opcode;

    modport master (
        output instr_valid,
        output opcode,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  opcode,
        output instr_ready
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: accepts one opcode per handshake, holds its
// decoded control fields while in flight and fires write/PC strobes on completion.
//
// state | meaning
// IDLE  | ready for an instruction
// EXEC  | first cycle after accept; non-memory ops complete here
// WAIT  | memory-latency cycles for lr/sr
// HALT  | illegal opcode trapped; left only through reset
module ctrl_sequencer #(
    parameter int OPC_W        = 3,
    parameter int MEM_LAT      = 1,
    parameter int ILLEGAL_HALT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    ctrl_sequencer_if.slave instr_if,
    input  logic       zero_flag_i,
    output logic       bez_o,
    output logic       ja_o,
    output logic       op1_o,
    output logic [1:0] op2_o,
    output logic [1:0] x8_sel_o,
    output logic       write_reg_o,
    output logic       write_x8_o,
    output logic       pc_en_o,
    output logic       branch_taken_o,
    output logic       illegal_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {IDLE, EXEC, WAIT, HALT} state_t;

    localparam bit         HAS_LAT  = (MEM_LAT > 0);
    localparam bit         HALT_ILL = (ILLEGAL_HALT != 0);
    localparam logic [2:0] LAT_M1   = HAS_LAT ? 3'(MEM_LAT - 1) : 3'd0;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic       bez_q, ja_q, op1_q, wreg_q, wx8_q, mem_q, ill_q;
    logic [1:0] op2_q, x8_sel_q;

    logic       dec_bez, dec_ja, dec_op1, dec_wreg, dec_wx8, dec_mem, dec_ill;
    logic [1:0] dec_op2, dec_x8_sel;

    logic accept, done, in_flight;

    always_comb begin
        dec_bez    = 1'b0;
        dec_ja     = 1'b0;
        dec_op1    = 1'b0;
        dec_op2    = 2'd0;
        dec_x8_sel = 2'd0;
        dec_wreg   = 1'b0;
        dec_wx8    = 1'b0;
        dec_mem    = 1'b0;
        dec_ill    = 1'b0;
        case (instr_if.opcode)
            OPC_W'(0): begin dec_bez = 1'b1; dec_op2 = 2'd1; end
            OPC_W'(1): begin dec_wx8 = 1'b1; dec_x8_sel = 2'd1; end
            OPC_W'(2): begin dec_ja = 1'b1; dec_op1 = 1'b1; dec_op2 = 2'd1; end
            OPC_W'(3): begin dec_wx8 = 1'b1; dec_x8_sel = 2'd1; end
            OPC_W'(4): begin dec_wx8 = 1'b1; dec_mem = 1'b1; end
            OPC_W'(5): begin dec_op1 = 1'b1; dec_wx8 = 1'b1; dec_x8_sel = 2'd2; end
            OPC_W'(6): begin dec_wreg = 1'b1; dec_mem = 1'b1; end
            default:   dec_ill = 1'b1;
        endcase
    end

    assign instr_if.instr_ready = (state_q == IDLE) && rst_n;
    assign accept = instr_if.instr_valid && instr_if.instr_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: begin
                if (ill_q && HALT_ILL) begin
                    state_d = HALT;
                end else if (mem_q && HAS_LAT) begin
                    state_d = WAIT;
                    cnt_d   = LAT_M1;
                end else begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            bez_q    <= 1'b0;
            ja_q     <= 1'b0;
            op1_q    <= 1'b0;
            op2_q    <= 2'd0;
            x8_sel_q <= 2'd0;
            wreg_q   <= 1'b0;
            wx8_q    <= 1'b0;
            mem_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                bez_q    <= dec_bez;
                ja_q     <= dec_ja;
                op1_q    <= dec_op1;
                op2_q    <= dec_op2;
                x8_sel_q <= dec_x8_sel;
                wreg_q   <= dec_wreg;
                wx8_q    <= dec_wx8;
                mem_q    <= dec_mem;
                ill_q    <= dec_ill;
            end
        end
    end

    // Held fields are visible only while the instruction is in flight.
    assign in_flight      = (state_q == EXEC) || (state_q == WAIT);
    assign bez_o          = in_flight && bez_q;
    assign ja_o           = in_flight && ja_q;
    assign op1_o          = in_flight && op1_q;
    assign op2_o          = in_flight ? op2_q : 2'd0;
    assign x8_sel_o       = in_flight ? x8_sel_q : 2'd0;
    assign write_reg_o    = done && wreg_q;
    assign write_x8_o     = done && wx8_q;
    assign pc_en_o        = done;
    assign branch_taken_o = done && (ja_q || (bez_q && zero_flag_i));
    assign illegal_o      = (state_q == HALT) || ((state_q == EXEC) && ill_q);
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: instance A (MEM_LAT=3, halt on illegal)
// and instance B (MEM_LAT=0, illegal as NOP) share one stimulus stream.
module tb_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [2:0] opc = 3'd0;
    logic       zf = 1'b0;

    int checks = 0;
    int failures = 0;
    int wx8_seen = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    ctrl_sequencer_if #(.OPC_W(3)) if_a ();
    ctrl_sequencer_if #(.OPC_W(3)) if_b ();

    assign if_a.instr_valid = valid;
    assign if_a.opcode      = opc;
    assign if_b.instr_valid = valid;
    assign if_b.opcode      = opc;

    logic       bez_a, ja_a, op1_a, wreg_a, wx8_a, pc_a, br_a, ill_a, busy_a;
    logic [1:0] op2_a, sel_a;
    logic       bez_b, ja_b, op1_b, wreg_b, wx8_b, pc_b, br_b, ill_b, busy_b;
    logic [1:0] op2_b, sel_b;

    ctrl_sequencer #(.OPC_W(3), .MEM_LAT(3), .ILLEGAL_HALT(1)) u_a (
        .clk(clk), .rst_n(rst_n), .instr_if(if_a), .zero_flag_i(zf),
        .bez_o(bez_a), .ja_o(ja_a), .op1_o(op1_a), .op2_o(op2_a), .x8_sel_o(sel_a),
        .write_reg_o(wreg_a), .write_x8_o(wx8_a), .pc_en_o(pc_a),
        .branch_taken_o(br_a), .illegal_o(ill_a), .busy_o(busy_a)
    );

    ctrl_sequencer #(.OPC_W(3), .MEM_LAT(0), .ILLEGAL_HALT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .instr_if(if_b), .zero_flag_i(zf),
        .bez_o(bez_b), .ja_o(ja_b), .op1_o(op1_b), .op2_o(op2_b), .x8_sel_o(sel_b),
        .write_reg_o(wreg_b), .write_x8_o(wx8_b), .pc_en_o(pc_b),
        .branch_taken_o(br_b), .illegal_o(ill_b), .busy_o(busy_b)
    );

    always @(negedge clk) if (mon_en && wx8_a) wx8_seen++;

    // {bez, ja, op1, op2[1:0], x8_sel[1:0], write_reg, write_x8, pc_en, branch_taken, illegal}
    function automatic logic [11:0] pack_a();
        return {bez_a, ja_a, op1_a, op2_a, sel_a, wreg_a, wx8_a, pc_a, br_a, ill_a};
    endfunction

    function automatic logic [11:0] pack_b();
        return {bez_b, ja_b, op1_b, op2_b, sel_b, wreg_b, wx8_b, pc_b, br_b, ill_b};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        string      name;
        logic [2:0] opc;
        logic       zf;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"bez_z1", 3'd0, 1'b1, 12'b1_0_0_01_00_0_0_1_1_0};
        vecs[1] = '{"bez_z0", 3'd0, 1'b0, 12'b1_0_0_01_00_0_0_1_0_0};
        vecs[2] = '{"li",     3'd1, 1'b0, 12'b0_0_0_00_01_0_1_1_0_0};
        vecs[3] = '{"ja",     3'd2, 1'b0, 12'b0_1_1_01_00_0_0_1_1_0};
        vecs[4] = '{"add",    3'd3, 1'b1, 12'b0_0_0_00_01_0_1_1_0_0};
        vecs[5] = '{"not",    3'd5, 1'b0, 12'b0_0_1_00_10_0_1_1_0_0};

        // Reset held with a valid instruction offered
        valid = 1'b1;
        opc   = 3'd3;
        tick();
        tick();
        chk("rst_outs_a", {20'd0, pack_a()}, 32'd0);
        chk("rst_outs_b", {20'd0, pack_b()}, 32'd0);
        chk("rst_rdy_busy", {if_a.instr_ready, if_b.instr_ready, busy_a, busy_b}, 32'd0);
        valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rel_rdy_busy", {if_a.instr_ready, if_b.instr_ready, busy_a, busy_b}, 32'b1100);

        // Single-cycle ops: identical on both instances
        foreach (vecs[i]) begin
            opc   = vecs[i].opc;
            zf    = vecs[i].zf;
            valid = 1'b1;
            tick();
            valid = 1'b0;
            chk({vecs[i].name, "_exec_a"}, {20'd0, pack_a()}, {20'd0, vecs[i].exp});
            chk({vecs[i].name, "_exec_b"}, {20'd0, pack_b()}, {20'd0, vecs[i].exp});
            tick();
            chk({vecs[i].name, "_idle"},
                {pack_a(), pack_b(), if_a.instr_ready, if_b.instr_ready},
                {24'd0, 2'b11});
        end

        // sr: A waits 3 extra cycles, B completes in EXEC
        zf    = 1'b0;
        opc   = 3'd6;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("sr_a_t%0d", k),
                {busy_a, wreg_a, pc_a, if_a.instr_ready},
                {(k <= 4), (k == 4), (k == 4), (k >= 5)});
            chk($sformatf("sr_b_t%0d", k),
                {busy_b, wreg_b, pc_b, if_b.instr_ready},
                {(k == 1), (k == 1), (k == 1), (k >= 2)});
            tick();
        end

        // lr on B with zero latency
        opc   = 3'd4;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("lr_b_exec", {20'd0, pack_b()}, {20'd0, 12'b0_0_0_00_00_0_1_1_0_0});
        // A is still busy with lr; reset lands in its WAIT cycles
        mon_en = 1'b1;
        tick();
        chk("lr_a_in_wait", {busy_a, pc_a}, 32'b10);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        mon_en = 1'b0;
        chk("lr_rst_no_wx8", wx8_seen, 0);
        chk("lr_rst_idle", {busy_a, if_a.instr_ready}, 32'b01);
        opc   = 3'd3;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("add_after_rst_a", {20'd0, pack_a()}, {20'd0, 12'b0_0_0_00_01_0_1_1_0_0});

        // Illegal opcode: A halts, B treats as NOP
        tick();
        opc   = 3'd7;
        valid = 1'b1;
        tick();
        chk("ill_a_exec", {wreg_a, wx8_a, pc_a}, 32'd0);
        chk("ill_b_exec", {wreg_b, wx8_b, pc_b, ill_b}, 32'b0011);
        opc = 3'd3;
        tick();
        chk("ill_b_after", {ill_b, if_b.instr_ready}, 32'b01);
        for (int k = 2; k <= 6; k++) begin
            chk($sformatf("halt_a_t%0d", k),
                {ill_a, if_a.instr_ready, busy_a, wreg_a, wx8_a, pc_a},
                32'b101000);
            tick();
        end
        valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("halt_cleared", {ill_a, if_a.instr_ready, busy_a}, 32'b010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
